// File: rtl/sobel_window_gen_if.sv
// Pixel-in / 3x3-window-out bundle for sobel_window_gen.
// The master side is the pixel source; the slave side is the window generator.
interface sobel_window_gen_if #(
    parameter int DW = 8
);
    logic [DW-1:0] pix_i;
    logic          pix_valid_i;
    logic          frame_start_i;
    logic [DW-1:0] d0_o;
    logic [DW-1:0] d1_o;
    logic [DW-1:0] d2_o;
    logic [DW-1:0] d3_o;
    logic [DW-1:0] d4_o;
    logic [DW-1:0] d5_o;
    logic [DW-1:0] d6_o;
    logic [DW-1:0] d7_o;
    logic [DW-1:0] d8_o;
    logic          done_o;
    logic          frame_done_o;

    modport master (
        output pix_i,
        output pix_valid_i,
        output frame_start_i,
        input  d0_o, d1_o, d2_o,
        input  d3_o, d4_o, d5_o,
        input  d6_o, d7_o, d8_o,
        input  done_o,
        input  frame_done_o
    );

    modport slave (
        input  pix_i,
        input  pix_valid_i,
        input  frame_start_i,
        output d0_o, d1_o, d2_o,
        output d3_o, d4_o, d5_o,
        output d6_o, d7_o, d8_o,
        output done_o,
        output frame_done_o
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Raster-scan 3x3 window generator with two line buffers.
// Emits one done_o strobe per window fully inside the frame.
module sobel_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8
) (
    input logic              clk,
    input logic              rst,
    sobel_window_gen_if.slave bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    logic [XW-1:0] x_q, x_d, x_cur;
    logic [YW-1:0] y_q, y_d, y_cur;

    logic [DW-1:0] lb1_mem [IMG_W];
    logic [DW-1:0] lb2_mem [IMG_W];
    logic [DW-1:0] lb1_rd;
    logic [DW-1:0] lb2_rd;

    logic [DW-1:0] win_q [9];
    logic [DW-1:0] win_d [9];

    logic done_q, done_d;
    logic fdone_q, fdone_d;
    logic accept;
    logic restart;

    // A qualified frame_start overrides the counters for this very pixel.
    always_comb begin
        accept  = bus.pix_valid_i;
        restart = bus.pix_valid_i && bus.frame_start_i;
        x_cur   = restart ? '0 : x_q;
        y_cur   = restart ? '0 : y_q;
        lb1_rd  = lb1_mem[x_cur];
        lb2_rd  = lb2_mem[x_cur];
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (x_cur == X_LAST) begin
                x_d = '0;
                y_d = (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
            end else begin
                x_d = x_cur + 1'b1;
                y_d = y_cur;
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb2_rd;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb1_rd;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = bus.pix_i;
        end
    end

    // Columns 0/1 of a line would mix in the previous row, so they never strobe.
    always_comb begin
        done_d  = accept && (x_cur >= X_TWO) && (y_cur >= Y_TWO);
        fdone_d = accept && (x_cur == X_LAST) && (y_cur == Y_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            fdone_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
            fdone_q <= fdone_d;
            win_q   <= win_d;
        end
    end

    // Read happens combinationally before the edge, so same-address
    // accesses see the old line contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[x_cur] <= bus.pix_i;
            lb2_mem[x_cur] <= lb1_rd;
        end
    end

    assign bus.d0_o         = win_q[0];
    assign bus.d1_o         = win_q[1];
    assign bus.d2_o         = win_q[2];
    assign bus.d3_o         = win_q[3];
    assign bus.d4_o         = win_q[4];
    assign bus.d5_o         = win_q[5];
    assign bus.d6_o         = win_q[6];
    assign bus.d7_o         = win_q[7];
    assign bus.d8_o         = win_q[8];
    assign bus.done_o       = done_q;
    assign bus.frame_done_o = fdone_q;
endmodule
